// File: rtl/pkt_ingress_buf.sv
// pkt_ingress_buf: per-port packet store-and-forward buffer with packet-level backpressure
module pkt_ingress_buf #(
  parameter int DEPTH = 1024,
  parameter int DESC_DEPTH = 8,
  parameter int XOFF_THRESH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_vld,
  input  logic [3:0]  in_dest,
  input  logic [8:0]  in_length,
  output logic        xfer_stop,
  output logic        drop,
  output logic [15:0] out_data,
  output logic        out_vld,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [3:0]  out_dest,
  output logic [8:0]  out_length
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DESC_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] XOFF_W = (AW+1)'(XOFF_THRESH);
  localparam logic [DW:0] DQ_MAX = (DW+1)'(DESC_DEPTH);
  localparam logic [DW:0] DQ_HI = (DW+1)'(DESC_DEPTH-1);
  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rstate_t;
  wstate_t wstate;
  rstate_t rstate;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wptr, wstart, raddr;
  logic [AW:0] used, free, used_nxt;
  logic [8:0] wlen, wcnt, rcnt;
  logic [3:0] wdest;
  logic [AW-1:0] dq_start [DESC_DEPTH];
  logic [8:0] dq_len [DESC_DEPTH];
  logic [3:0] dq_dest [DESC_DEPTH];
  logic [DW-1:0] dq_wp, dq_rp;
  logic [DW:0] dq_cnt;
  logic start_pkt, admit, reserve, wr_en, last_w, push, pop, xfer;
  logic [AW-1:0] push_start;
  logic [8:0] push_len;
  logic [3:0] push_dest;
  always_comb begin
    free = DEPTH_W - used;
    start_pkt = wstate == W_IDLE && in_vld;
    admit = in_length != 9'd0 && free >= (AW+1)'(in_length) && dq_cnt < DQ_MAX;
    reserve = start_pkt && admit;
    wr_en = reserve || (wstate == W_STORE && in_vld);
    last_w = wstate == W_STORE && in_vld && wcnt + 9'd1 == wlen;
    push = (reserve && in_length == 9'd1) || last_w;
    push_start = start_pkt ? wptr : wstart;
    push_len = start_pkt ? in_length : wlen;
    push_dest = start_pkt ? in_dest : wdest;
    pop = rstate == R_IDLE && dq_cnt != '0;
    xfer = rstate == R_SEND && out_ready;
    used_nxt = used + (reserve ? (AW+1)'(in_length) : '0) - (AW+1)'(xfer);
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
      wptr <= '0;
      wstart <= '0;
      raddr <= '0;
      used <= '0;
      wlen <= '0;
      wcnt <= '0;
      wdest <= '0;
      rcnt <= '0;
      dq_wp <= '0;
      dq_rp <= '0;
      dq_cnt <= '0;
      xfer_stop <= 1'b0;
      drop <= 1'b0;
      out_data <= '0;
      out_vld <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_dest <= '0;
      out_length <= '0;
    end else begin
      drop <= 1'b0;
      used <= used_nxt;
      xfer_stop <= free < XOFF_W || dq_cnt >= DQ_HI;
      dq_cnt <= dq_cnt + (DW+1)'(push) - (DW+1)'(pop);
      if (wr_en) wptr <= wptr + 1'b1;
      if (push) begin
        dq_start[dq_wp] <= push_start;
        dq_len[dq_wp] <= push_len;
        dq_dest[dq_wp] <= push_dest;
        dq_wp <= dq_wp + 1'b1;
      end
      if (pop) dq_rp <= dq_rp + 1'b1;
      case (wstate)
        W_IDLE: if (in_vld) begin
          wlen <= in_length;
          wdest <= in_dest;
          wstart <= wptr;
          wcnt <= 9'd1;
          drop <= !admit;
          if (in_length > 9'd1) wstate <= admit ? W_STORE : W_DROP;
        end
        W_STORE: if (in_vld) begin
          wcnt <= wcnt + 9'd1;
          if (last_w) wstate <= W_IDLE;
        end
        W_DROP: if (in_vld) begin
          wcnt <= wcnt + 9'd1;
          if (wcnt + 9'd1 == wlen) wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
      case (rstate)
        R_IDLE: if (pop) begin
          raddr <= dq_start[dq_rp];
          out_dest <= dq_dest[dq_rp];
          out_length <= dq_len[dq_rp];
          rstate <= R_FETCH;
        end
        R_FETCH: begin
          out_data <= mem[raddr];
          raddr <= raddr + 1'b1;
          out_vld <= 1'b1;
          out_sop <= 1'b1;
          out_eop <= out_length == 9'd1;
          rcnt <= '0;
          rstate <= R_SEND;
        end
        R_SEND: if (out_ready) begin
          if (out_eop) begin
            out_vld <= 1'b0;
            out_sop <= 1'b0;
            out_eop <= 1'b0;
            rstate <= R_IDLE;
          end else begin
            out_data <= mem[raddr];
            raddr <= raddr + 1'b1;
            rcnt <= rcnt + 9'd1;
            out_sop <= 1'b0;
            out_eop <= rcnt + 9'd2 == out_length;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule
